// File: rtl/booth_operand_sequencer_if.sv
// Operand-in and result-out handshake bundle for the Booth front-end.
// master = operand source / result consumer, slave = sequencer.
interface booth_operand_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic [TAG_W-1:0]   in_tag;
   logic               res_valid;
   logic               res_ready;
   logic [2*WIDTH-1:0] res_data;
   logic [TAG_W-1:0]   res_tag;

   modport master (
      output in_valid, in_a, in_b, in_tag, res_ready,
      input  in_ready, res_valid, res_data, res_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_tag, res_ready,
      output in_ready, res_valid, res_data, res_tag
   );
endinterface

// File: rtl/booth_operand_sequencer.sv
// Operand FIFO and sequencer in front of the radix-4 Booth multiplier.
// Holds the head pair for CYCLES enabled edges, then captures the product.
module booth_operand_sequencer #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 4,
   parameter int CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   booth_operand_sequencer_if.slave   io,
   output logic [WIDTH-1:0]           mul_a,
   output logic [WIDTH-1:0]           mul_b,
   output logic                       mul_en,
   output logic                       mul_reset,
   input  logic [2*WIDTH-1:0]         mul_result,
   input  logic                       mul_done,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       busy,
   output logic                       err
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam int BW = $clog2(CYCLES);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_RUN,
      S_WAIT
   } state_t;

   state_t state, nxt;

   logic [WIDTH-1:0]   mem_a   [DEPTH];
   logic [WIDTH-1:0]   mem_b   [DEPTH];
   logic [TAG_W-1:0]   mem_tag [DEPTH];
   logic [AW-1:0]      wptr, rptr;
   logic [LW-1:0]      cnt;
   logic [BW-1:0]      beat;
   logic               rv;
   logic [2*WIDTH-1:0] rdata;
   logic [TAG_W-1:0]   rtag;
   logic               push, pop;

   assign io.in_ready = (cnt < LW'(DEPTH)) && (state != S_INIT);
   assign push = io.in_valid && io.in_ready;
   assign pop  = (state == S_WAIT) && mul_done;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wptr]   <= io.in_a;
         mem_b[wptr]   <= io.in_b;
         mem_tag[wptr] <= io.in_tag;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         if (push && !pop)      cnt <= cnt + LW'(1);
         else if (pop && !push) cnt <= cnt - LW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_INIT;
         beat  <= '0;
      end else begin
         state <= nxt;
         beat  <= (state == S_RUN) ? beat + BW'(1) : '0;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_INIT: nxt = S_IDLE;
         S_IDLE: if (cnt != '0 && !rv) nxt = S_RUN;
         S_RUN:  if (beat == BW'(CYCLES-1)) nxt = S_WAIT;
         S_WAIT: if (mul_done) nxt = S_IDLE;
         default: nxt = S_INIT;
      endcase
   end

   // Capture can only occur with rv low: RUN is never entered while a result is held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rv    <= 1'b0;
         rdata <= '0;
         rtag  <= '0;
         err   <= 1'b0;
      end else begin
         if (pop) begin
            rv    <= 1'b1;
            rdata <= mul_result;
            rtag  <= mem_tag[rptr];
         end else if (rv && io.res_ready) begin
            rv <= 1'b0;
         end
         if (state == S_WAIT && !mul_done) err <= 1'b1;
      end
   end

   assign io.res_valid = rv;
   assign io.res_data  = rdata;
   assign io.res_tag   = rtag;

   assign mul_a     = mem_a[rptr];
   assign mul_b     = mem_b[rptr];
   assign mul_en    = (state == S_INIT) || (state == S_RUN);
   assign mul_reset = (state == S_INIT);
   assign busy      = (state == S_RUN) || (state == S_WAIT);
   assign level     = cnt;
endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Directed bench for booth_operand_sequencer with a behavioural
// 16-step multiplier model driving mul_done/mul_result.
module tb_booth_operand_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   booth_operand_sequencer_if #(.WIDTH(32), .TAG_W(4)) bus();

   logic [31:0] mul_a, mul_b;
   logic        mul_en, mul_reset, mul_done, busy, err;
   logic [63:0] mul_result;
   logic [2:0]  level;

   booth_operand_sequencer #(
      .WIDTH(32), .DEPTH(4), .TAG_W(4), .CYCLES(16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .io         (bus),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_en     (mul_en),
      .mul_reset  (mul_reset),
      .mul_result (mul_result),
      .mul_done   (mul_done),
      .level      (level),
      .busy       (busy),
      .err        (err)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Multiplier model: step counter cleared by en&reset, done after 16 steps.
   logic [4:0] mcnt = 5'd20;
   logic       hold_done = 1'b0;
   logic signed [63:0] pa, pb;
   assign pa = {{32{mul_a[31]}}, mul_a};
   assign pb = {{32{mul_b[31]}}, mul_b};
   always @(posedge clk) begin
      if (mul_en) begin
         if (mul_reset)          mcnt <= 5'd0;
         else if (mcnt == 5'd16) mcnt <= 5'd1;
         else                    mcnt <= mcnt + 5'd1;
      end
   end
   assign mul_done   = (mcnt == 5'd16) && !hold_done;
   assign mul_result = mul_done ? pa * pb : 64'h0BAD_0BAD_0BAD_0BAD;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] la = '0, lb = '0;
   logic        was_busy = 1'b0;
   int          unstable = 0;
   always @(negedge clk) begin
      if (busy && was_busy && (mul_a !== la || mul_b !== lb))
         unstable <= unstable + 1;
      la <= mul_a;
      lb <= mul_b;
      was_busy <= busy;
   end

   int last_t = 0;

   task automatic push(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t);
      bus.in_a = a;
      bus.in_b = b;
      bus.in_tag = t;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (bus.in_ready) begin
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("push_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_res(input string tag, input logic [63:0] d,
                           input logic [3:0] t);
      for (int i = 0; i < 80; i++) begin
         if (bus.res_valid) begin
            last_t = cyc;
            chk({tag, "_data"}, bus.res_data, d);
            chk({tag, "_tag"}, 64'(bus.res_tag), 64'(t));
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      chk({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   int k, en_cnt, busy_cnt, t0;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.in_tag = '0;
      bus.res_ready = 1'b0;
      #2 reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_rvalid", 64'(bus.res_valid), 64'd0);
      chk("rst_rdata", bus.res_data, 64'd0);
      chk("rst_rtag", 64'(bus.res_tag), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_inrdy", 64'(bus.in_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      reset = 1'b1;
      #1;
      chk("init_en", 64'(mul_en), 64'd1);
      chk("init_mrst", 64'(mul_reset), 64'd1);
      chk("init_inrdy", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      chk("idle_inrdy", 64'(bus.in_ready), 64'd1);
      chk("idle_en", 64'({mul_en, mul_reset}), 64'd0);

      // single pair: latency and enable count
      bus.res_ready = 1'b1;
      bus.in_a = 32'd7;
      bus.in_b = 32'hFFFF_FFFD;
      bus.in_tag = 4'd5;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      k = 0;
      en_cnt = 0;
      while (!bus.res_valid && k < 40) begin
         if (mul_en) en_cnt++;
         @(negedge clk);
         k++;
      end
      chk("lat", 64'(k), 64'd18);
      chk("en_cycles", 64'(en_cnt), 64'd16);
      chk("p1_data", bus.res_data, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("p1_tag", 64'(bus.res_tag), 64'd5);
      @(negedge clk);
      chk("p1_drop", 64'(bus.res_valid), 64'd0);

      // fill the FIFO with res_ready low
      bus.res_ready = 1'b0;
      push(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd1);
      push(32'h8000_0000, 32'h8000_0000, 4'd2);
      push(32'd0, 32'd123, 4'd3);
      push(32'hFFFF_FFFF, 32'd1, 4'd4);
      chk("full_level", 64'(level), 64'd4);
      chk("full_inrdy", 64'(bus.in_ready), 64'd0);

      // fifth offer pending across the capture edge
      bus.in_a = 32'd2;
      bus.in_b = 32'd3;
      bus.in_tag = 4'd5;
      bus.in_valid = 1'b1;
      k = 0;
      while (!bus.res_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("pop_level", 64'(level), 64'd3);
      chk("pop_inrdy", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("refill_level", 64'(level), 64'd4);
      chk("max_data", bus.res_data, 64'h3FFF_FFFF_0000_0001);
      chk("max_tag", 64'(bus.res_tag), 64'd1);

      busy_cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      chk("hold_norun", 64'(busy_cnt), 64'd0);
      chk("hold_valid", 64'(bus.res_valid), 64'd1);
      chk("hold_data", bus.res_data, 64'h3FFF_FFFF_0000_0001);

      // drain stream
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("rel_drop", 64'(bus.res_valid), 64'd0);
      wait_res("p_min", 64'h4000_0000_0000_0000, 4'd2);
      wait_res("p_zero", 64'd0, 4'd3);
      t0 = last_t;
      wait_res("p_neg", 64'hFFFF_FFFF_FFFF_FFFF, 4'd4);
      chk("thruput", 64'(last_t - t0), 64'd19);
      wait_res("p_six", 64'd6, 4'd5);
      chk("operand_stable", 64'(unstable), 64'd0);
      chk("drain_level", 64'(level), 64'd0);

      // reset in the middle of a RUN
      push(32'd5, 32'd5, 4'd6);
      repeat (9) @(negedge clk);
      chk("mid_busy", 64'({busy, mul_en}), 64'd3);
      reset = 1'b0;
      #1;
      chk("mid_level", 64'(level), 64'd0);
      chk("mid_rvalid", 64'(bus.res_valid), 64'd0);
      chk("mid_busy0", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reinit", 64'({mul_en, mul_reset}), 64'd3);
      @(negedge clk);
      chk("reinit_idle", 64'(bus.in_ready), 64'd1);
      push(32'd9, 32'd9, 4'd7);
      wait_res("p81", 64'd81, 4'd7);

      // multiplier late with done
      hold_done = 1'b1;
      push(32'd3, 32'd4, 4'd8);
      k = 0;
      while (!(busy && !mul_en) && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("wait_reached", 64'({busy, mul_en}), 64'd2);
      chk("err_pre", 64'(err), 64'd0);
      repeat (3) begin
         @(negedge clk);
         chk("wait_hold", 64'({busy, bus.res_valid}), 64'd2);
      end
      chk("err_set", 64'(err), 64'd1);
      hold_done = 1'b0;
      @(negedge clk);
      chk("late_valid", 64'(bus.res_valid), 64'd1);
      chk("late_data", bus.res_data, 64'd12);
      chk("late_tag", 64'(bus.res_tag), 64'd8);
      repeat (3) @(negedge clk);
      chk("err_sticky", 64'(err), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
